// File: rtl/seq_divider50_20_pkg.sv
// Shared widths, FSM state type and divide-by-zero constant for the
// sequential 50/20-bit restoring divider.
package seq_divider50_20_pkg;

    localparam int unsigned DIVIDEND_W_DEF = 50;
    localparam int unsigned DIVISOR_W_DEF  = 20;
    localparam int unsigned CNT_W_DEF      = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [DIVIDEND_W_DEF-1:0] QUOT_DIV0 = '1;

endpackage

// File: rtl/seq_divider50_20_unsigned_subtractor21.sv
// Combinational ripple-borrow subtractor: diff = a - b, borrow set when a < b.
module unsigned_subtractor21 #(
    parameter int unsigned W = 21
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);

    logic carry;

    // a - b computed as a + ~b + 1; no carry out means a borrow occurred.
    always_comb begin
        diff  = '0;
        carry = 1'b1;
        for (int unsigned i = 0; i < W; i++) begin
            diff[i] = a[i] ^ ~b[i] ^ carry;
            carry   = (a[i] & ~b[i]) | (a[i] & carry) | (~b[i] & carry);
        end
        borrow = ~carry;
    end

endmodule

// File: rtl/seq_divider50_20.sv
// Iterative unsigned restoring divider, one quotient bit per cycle, with
// valid/ready handshakes on operands and result.
module seq_divider50_20
    import seq_divider50_20_pkg::*;
#(
    parameter int unsigned DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int unsigned DIVISOR_W  = DIVISOR_W_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIVIDEND_W - 1);

    state_e                state_q, state_d;
    logic [DIVIDEND_W-1:0] q_q, q_d;
    logic [DIVISOR_W:0]    r_q, r_d;
    logic [DIVISOR_W-1:0]  d_q, d_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
    logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
    logic                  div_by_zero_q, div_by_zero_d;

    logic [DIVISOR_W:0]    t;
    logic [DIVISOR_W:0]    s;
    logic [DIVISOR_W:0]    r_iter;
    logic                  borrow;
    logic                  qbit;

    // R < D after every step, so the top bit of R never feeds the next shift.
    logic unused_r_msb;
    assign unused_r_msb = r_q[DIVISOR_W];

    assign t = {r_q[DIVISOR_W-1:0], q_q[DIVIDEND_W-1]};

    unsigned_subtractor21 #(
        .W (DIVISOR_W + 1)
    ) u_sub (
        .a      (t),
        .b      ({1'b0, d_q}),
        .diff   (s),
        .borrow (borrow)
    );

    assign qbit   = ~borrow;
    assign r_iter = borrow ? t : s;

    always_comb begin
        state_d       = state_q;
        q_d           = q_q;
        r_d           = r_q;
        d_d           = d_q;
        cnt_d         = cnt_q;
        in_ready_d    = in_ready_q;
        out_valid_d   = out_valid_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    q_d           = dividend;
                    r_d           = '0;
                    d_d           = divisor;
                    cnt_d         = '0;
                    in_ready_d    = 1'b0;
                    div_by_zero_d = 1'b0;
                    if (divisor == '0) begin
                        state_d       = ST_DONE;
                        out_valid_d   = 1'b1;
                        quotient_d    = DIVIDEND_W'(QUOT_DIV0);
                        remainder_d   = '0;
                        div_by_zero_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                r_d   = r_iter;
                q_d   = {q_q[DIVIDEND_W-2:0], qbit};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    quotient_d  = {q_q[DIVIDEND_W-2:0], qbit};
                    remainder_d = r_iter[DIVISOR_W-1:0];
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            q_q           <= '0;
            r_q           <= '0;
            d_q           <= '0;
            cnt_q         <= '0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            q_q           <= q_d;
            r_q           <= r_d;
            d_q           <= d_d;
            cnt_q         <= cnt_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_seq_divider50_20.sv
// Directed and random checks of seq_divider50_20 against plain '/' and '%'.
module tb_seq_divider50_20;

    localparam int unsigned AW = 50;
    localparam int unsigned BW = 20;
    localparam longint unsigned AMASK = (64'd1 << AW) - 64'd1;
    localparam longint unsigned BMASK = (64'd1 << BW) - 64'd1;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] dividend;
    logic [BW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] quotient;
    logic [BW-1:0] remainder;
    logic          div_by_zero;

    int errors = 0;
    int checks = 0;

    seq_divider50_20 #(
        .DIVIDEND_W (AW),
        .DIVISOR_W  (BW),
        .CNT_W      (6)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer division; B==0 yields all-ones / 0 / flag.
    task automatic model(input longint unsigned a, input longint unsigned b,
                         output longint unsigned q, output longint unsigned r,
                         output longint unsigned z, output int lat);
        if (b == 0) begin
            q = AMASK; r = 0; z = 1; lat = 1;
        end else begin
            q = a / b; r = a % b; z = 0; lat = AW + 1;
        end
    endtask

    task automatic do_div(input string tag, input longint unsigned a, input longint unsigned b);
        longint unsigned eq, er, ez;
        int elat;
        int n;
        model(a, b, eq, er, ez, elat);
        n = 0;
        while (!in_ready && n < 200) begin
            step();
            n++;
        end
        chk({tag, ".in_ready"}, longint'(in_ready), 1);
        in_valid = 1'b1;
        dividend = AW'(a);
        divisor  = BW'(b);
        step();
        in_valid = 1'b0;
        // operands and in_valid wiggle after acceptance and must be ignored
        n = 1;
        while (!out_valid && n < 120) begin
            dividend = AW'({$urandom, $urandom});
            divisor  = BW'($urandom);
            in_valid = $urandom_range(0, 1) == 1;
            step();
            n++;
        end
        in_valid = 1'b0;
        chk({tag, ".latency"}, longint'(n), longint'(elat));
        chk({tag, ".quotient"}, longint'(quotient), eq);
        chk({tag, ".remainder"}, longint'(remainder), er);
        chk({tag, ".div_by_zero"}, longint'(div_by_zero), ez);
        chk({tag, ".busy_ready"}, longint'(in_ready), 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, ".out_valid_clr"}, longint'(out_valid), 0);
        chk({tag, ".ready_back"}, longint'(in_ready), 1);
    endtask

    initial begin
        longint unsigned ra, rb, hq;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #12;
        chk("rst.in_ready", longint'(in_ready), 1);
        chk("rst.out_valid", longint'(out_valid), 0);
        chk("rst.quotient", longint'(quotient), 0);
        chk("rst.remainder", longint'(remainder), 0);
        chk("rst.dbz", longint'(div_by_zero), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        do_div("d100_7", 100, 7);
        do_div("max_max", AMASK, BMASK);
        do_div("max_1", AMASK, 1);
        do_div("a_lt_b", 5, 9);
        do_div("zero_a", 0, 3);
        do_div("div0", 123, 0);
        do_div("after_div0", 100, 7);
        do_div("max_0", AMASK, 0);
        do_div("b_eq_a", 777, 777);

        // Result held while the consumer stalls; a new request is refused.
        in_valid = 1'b1; dividend = AW'(1000); divisor = BW'(33);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 60 && !out_valid; i++) step();
        chk("hold.valid0", longint'(out_valid), 1);
        hq = longint'(quotient);
        in_valid = 1'b1; dividend = AW'(55); divisor = BW'(0);
        for (int i = 0; i < 10; i++) step();
        chk("hold.valid", longint'(out_valid), 1);
        chk("hold.quotient", longint'(quotient), 1000 / 33);
        chk("hold.stable", longint'(quotient), hq);
        chk("hold.remainder", longint'(remainder), 1000 % 33);
        chk("hold.in_ready", longint'(in_ready), 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("hold.release_valid", longint'(out_valid), 0);
        chk("hold.release_ready", longint'(in_ready), 1);

        // Asynchronous reset twenty cycles into an operation.
        in_valid = 1'b1; dividend = AW'(AMASK); divisor = BW'(3);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        #3;
        rst_n = 1'b0;
        #1;
        chk("mrst.in_ready", longint'(in_ready), 1);
        chk("mrst.out_valid", longint'(out_valid), 0);
        chk("mrst.quotient", longint'(quotient), 0);
        chk("mrst.remainder", longint'(remainder), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) step();
        chk("mrst.no_partial", longint'(out_valid), 0);
        do_div("mrst_fresh", 100, 7);

        for (int k = 0; k < 24; k++) begin
            ra = {$urandom, $urandom} & AMASK;
            ra = ra >> $urandom_range(0, AW - 1);
            rb = longint'($urandom) & BMASK;
            rb = rb >> $urandom_range(0, BW - 1);
            if (k == 7) rb = 0;
            do_div($sformatf("rnd%0d", k), ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
